mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 33 +++
 rtl/mem_access_unit.sv | 153 +++++++++++++++
 tb/tb_mem_access_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Core request / response and word-memory bus for mem_access_unit.
// Signal names are seen from the unit: i_* driven by core/memory, o_* by the unit.
interface mem_access_unit_if;
  logic        i_reqValid;
  logic        o_reqReady;
  logic        i_reqWrite;
  logic [2:0]  i_reqFunct3;
  logic [31:0] i_reqAddress;
  logic [31:0] i_reqWriteData;
  logic        o_rspValid;
  logic [31:0] o_rspReadData;
  logic        o_rspError;
  logic [31:0] o_memAddress;
  logic        o_memWriteEnable;
  logic [31:0] o_memWriteData;
  logic [31:0] i_memReadData;

  modport slave (
    input  i_reqValid, i_reqWrite, i_reqFunct3,
    input  i_reqAddress, i_reqWriteData, i_memReadData,
    output o_reqReady, o_rspValid, o_rspReadData,
    output o_rspError, o_memAddress, o_memWriteEnable,
    output o_memWriteData
  );

  modport master (
    output i_reqValid, i_reqWrite, i_reqFunct3,
    output i_reqAddress, i_reqWriteData, i_memReadData,
    input  o_reqReady, o_rspValid, o_rspReadData,
    input  o_rspError, o_memAddress, o_memWriteEnable,
    input  o_memWriteData
  );
endinterface

// File: rtl/mem_access_unit.sv
// RV32I load/store unit over a 32-bit word memory with read-modify-write for SB/SH.
// Optional macro MEM_ACCESS_MISALIGN_TRAP_EN turns misaligned LH/LHU/SH/LW/SW into errors.
module mem_access_unit (
  input  logic              i_clk,
  input  logic              i_rst,
  mem_access_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_write;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_legal;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;
  logic [31:0] w_merge;

  assign w_accept = bus.i_reqValid && (r_state == IDLE);

  // Decide at accept time whether the request may touch memory
  always_comb begin
    w_legal = 1'b0;
    if (bus.i_reqWrite)
      w_legal = (bus.i_reqFunct3 <= 3'd2);
    else
      w_legal = (bus.i_reqFunct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    if (bus.i_reqFunct3[1:0] == 2'b01 && bus.i_reqAddress[0])
      w_legal = 1'b0;
    if (bus.i_reqFunct3[1:0] == 2'b10 && bus.i_reqAddress[1:0] != 2'b00)
      w_legal = 1'b0;
`endif
  end

  // State register plus request latch and read-word capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_write  <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_write  <= bus.i_reqWrite;
        r_funct3 <= bus.i_reqFunct3;
        r_addr   <= bus.i_reqAddress;
        r_wdata  <= bus.i_reqWriteData;
        r_err    <= !w_legal;
      end
      if (r_state == READ)
        r_rdata <= bus.i_memReadData;
    end
  end

  // Lane extraction with sign/zero extension for loads
  always_comb begin
    w_byte = 8'd0;
    unique case (r_addr[1:0])
      2'd0: w_byte = r_rdata[7:0];
      2'd1: w_byte = r_rdata[15:8];
      2'd2: w_byte = r_rdata[23:16];
      2'd3: w_byte = r_rdata[31:24];
    endcase
    w_half = r_addr[1] ? r_rdata[31:16] : r_rdata[15:0];
    w_ext = 32'd0;
    case (r_funct3)
      3'd0:    w_ext = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_ext = {{16{w_half[15]}}, w_half};
      3'd2:    w_ext = r_rdata;
      3'd4:    w_ext = {24'd0, w_byte};
      3'd5:    w_ext = {16'd0, w_half};
      default: w_ext = 32'd0;
    endcase
  end

  // Store word: whole word for SW, lane-replaced read word for SB/SH
  always_comb begin
    w_merge = r_rdata;
    case (r_funct3)
      3'd0: begin
        unique case (r_addr[1:0])
          2'd0: w_merge[7:0]   = r_wdata[7:0];
          2'd1: w_merge[15:8]  = r_wdata[7:0];
          2'd2: w_merge[23:16] = r_wdata[7:0];
          2'd3: w_merge[31:24] = r_wdata[7:0];
        endcase
      end
      3'd1: begin
        if (r_addr[1])
          w_merge[31:16] = r_wdata[15:0];
        else
          w_merge[15:0] = r_wdata[15:0];
      end
      default: w_merge = r_wdata;
    endcase
  end

  // Next-state and handshake/bus outputs
  always_comb begin
    w_next                = r_state;
    bus.o_reqReady        = 1'b0;
    bus.o_rspValid        = 1'b0;
    bus.o_rspError        = 1'b0;
    bus.o_rspReadData     = 32'd0;
    bus.o_memWriteEnable  = 1'b0;
    bus.o_memAddress      = {r_addr[31:2], 2'b00};
    bus.o_memWriteData    = w_merge;
    unique case (r_state)
      IDLE: begin
        bus.o_reqReady = 1'b1;
        if (w_accept) begin
          if (!w_legal)
            w_next = RESP;
          else if (bus.i_reqWrite && bus.i_reqFunct3 == 3'd2)
            w_next = WRITE;
          else
            w_next = READ;
        end
      end
      READ:  w_next = r_write ? WRITE : RESP;
      WRITE: begin
        bus.o_memWriteEnable = !i_rst;
        w_next = RESP;
      end
      RESP: begin
        bus.o_rspValid = 1'b1;
        bus.o_rspError = r_err;
        if (!r_err && !r_write)
          bus.o_rspReadData = w_ext;
        w_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a behavioural load/store model.
// Honours MEM_ACCESS_MISALIGN_TRAP_EN the same way as the design.
module tb_mem_access_unit;

  logic clk;
  logic rst;
  logic mem_init;
  int   pass_cnt;
  int   total_cnt;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];

  mem_access_unit_if bus ();

  mem_access_unit u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] seed(int i);
    if (i == 4) return 32'h8899AABB;
    if (i == 8) return 32'h11223344;
    return (32'(i) * 32'h9E3779B1) ^ 32'hC3A55A3C;
  endfunction

  assign bus.i_memReadData = mem[bus.o_memAddress[7:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= seed(i);
    end else if (bus.o_memWriteEnable) begin
      mem[bus.o_memAddress[7:2]] <= bus.o_memWriteData;
    end
  end

  task automatic chk32(string nm, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%b required=%b", nm, act, exp);
  endtask

  task automatic do_req(input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
    logic        legal;
    logic        seen;
    int          lat;
    int          we_k;
    int          idx;
    int          sh;
    int          sh16;
    logic [31:0] old;
    logic [31:0] nw;
    logic [31:0] exp_rd;
    logic [31:0] v;
    idx  = int'(a[7:2]);
    old  = ref_mem[idx];
    sh   = 8 * int'(a[1:0]);
    sh16 = 16 * int'(a[1]);
    legal = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) legal = 1'b0;
    if (f3 == 3'd2 && a[1:0] != 2'b00) legal = 1'b0;
`endif
    exp_rd = 32'd0;
    nw     = old;
    if (legal && !w) begin
      case (f3)
        3'd0: begin v = (old >> sh) & 32'hFF; exp_rd = (v ^ 32'h80) - 32'h80; end
        3'd1: begin v = (old >> sh16) & 32'hFFFF; exp_rd = (v ^ 32'h8000) - 32'h8000; end
        3'd2: exp_rd = old;
        3'd4: exp_rd = (old >> sh) & 32'hFF;
        default: exp_rd = (old >> sh16) & 32'hFFFF;
      endcase
    end
    if (legal && w) begin
      case (f3)
        3'd0: nw = (old & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
        3'd1: nw = (old & ~(32'hFFFF << sh16)) | ((wd & 32'hFFFF) << sh16);
        default: nw = wd;
      endcase
    end
    if (!legal) lat = 1;
    else if (!w || f3 == 3'd2) lat = 2;
    else lat = 3;
    we_k = (legal && w) ? lat - 1 : 0;
    rd = 32'd0;
    er = 1'b0;

    @(negedge clk);
    chk1("ready_idle", bus.o_reqReady, 1'b1);
    bus.i_reqValid     = 1'b1;
    bus.i_reqWrite     = w;
    bus.i_reqFunct3    = f3;
    bus.i_reqAddress   = a;
    bus.i_reqWriteData = wd;
    @(posedge clk);
    #1;
    bus.i_reqValid     = 1'($urandom);
    bus.i_reqWrite     = 1'($urandom);
    bus.i_reqFunct3    = 3'($urandom);
    bus.i_reqAddress   = $urandom;
    bus.i_reqWriteData = $urandom;
    seen = 1'b0;
    for (int k = 1; k <= lat && !seen; k++) begin
      @(negedge clk);
      chk1("ready_busy", bus.o_reqReady, 1'b0);
      chk1("rsp_valid", bus.o_rspValid, k == lat);
      chk1("mem_we", bus.o_memWriteEnable, k == we_k);
      chk32("mem_addr", bus.o_memAddress, {a[31:2], 2'b00});
      if (k == we_k) chk32("mem_wdata", bus.o_memWriteData, nw);
      if (bus.o_rspValid) begin
        seen = 1'b1;
        rd = bus.o_rspReadData;
        er = bus.o_rspError;
        chk32("rsp_data", bus.o_rspReadData, exp_rd);
        chk1("rsp_err", bus.o_rspError, !legal);
      end else begin
        chk32("idle_data", bus.o_rspReadData, 32'd0);
        chk1("idle_err", bus.o_rspError, 1'b0);
      end
    end
    bus.i_reqValid = 1'b0;
    ref_mem[idx] = nw;
    chk32("mem_word", mem[idx], nw);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    mem_init  = 1'b1;
    bus.i_reqValid     = 1'b0;
    bus.i_reqWrite     = 1'b0;
    bus.i_reqFunct3    = 3'd0;
    bus.i_reqAddress   = 32'd0;
    bus.i_reqWriteData = 32'd0;
    for (int i = 0; i < 64; i++) ref_mem[i] = seed(i);
    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk);
    chk1("rst_ready", bus.o_reqReady, 1'b1);
    chk1("rst_rspv", bus.o_rspValid, 1'b0);
    chk1("rst_err", bus.o_rspError, 1'b0);
    chk1("rst_we", bus.o_memWriteEnable, 1'b0);
    chk32("rst_rdata", bus.o_rspReadData, 32'd0);
    chk32("rst_addr", bus.o_memAddress, 32'd0);
    chk32("rst_wdata", bus.o_memWriteData, 32'd0);
    rst = 1'b0;

    do_req(1'b0, 3'd0, 32'h11, 32'd0, rd, er);
    chk32("lit_LB", rd, 32'hFFFFFFAA);
    do_req(1'b0, 3'd4, 32'h11, 32'd0, rd, er);
    chk32("lit_LBU", rd, 32'h000000AA);
    do_req(1'b1, 3'd1, 32'h22, 32'h0000BEEF, rd, er);
    chk32("lit_SH", mem[8], 32'hBEEF3344);
    do_req(1'b1, 3'd2, 32'h3C, 32'hDEADBEEF, rd, er);
    chk32("lit_SW", mem[15], 32'hDEADBEEF);
    do_req(1'b0, 3'd3, 32'h40, 32'd0, rd, er);
    chk1("lit_ill_err", er, 1'b1);
    chk32("lit_ill_data", rd, 32'd0);
    do_req(1'b0, 3'd2, 32'h06, 32'd0, rd, er);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    chk1("lit_LW_mis", er, 1'b1);
`else
    chk32("lit_LW_mis", rd, 32'h7E7E7E7E ^ 32'h81DB5B45 ^ 32'h9E3779B1 ^ 32'hC3A55A3C ^ 32'h7E7E7E7E ^ 32'h81DB5B45);
`endif

    for (int n = 0; n < 300; n++) begin
      do_req(1'($urandom), 3'($urandom), $urandom, $urandom, rd, er);
    end

    @(negedge clk);
    chk1("abort_ready0", bus.o_reqReady, 1'b1);
    bus.i_reqValid     = 1'b1;
    bus.i_reqWrite     = 1'b1;
    bus.i_reqFunct3    = 3'd0;
    bus.i_reqAddress   = 32'h21;
    bus.i_reqWriteData = 32'h55;
    @(posedge clk);
    #1 bus.i_reqValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk1("abort_we_pre", bus.o_memWriteEnable, 1'b1);
    rst = 1'b1;
    #1;
    chk1("abort_we_rst", bus.o_memWriteEnable, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("abort_ready", bus.o_reqReady, 1'b1);
      chk1("abort_norsp", bus.o_rspValid, 1'b0);
    end
    chk32("abort_mem", mem[8], ref_mem[8]);
    do_req(1'b0, 3'd2, 32'h20, 32'd0, rd, er);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
